// File: rtl/nfc_po_latch_sequencer.sv
// nfc_po_latch_sequencer
//   Drives the SDR physical-output vectors for NAND command latch, address
//   latch and data-input cycles. One byte is accepted per valid/ready
//   handshake. The block then walks it through setup, WE-low, WE-high and
//   optional hold phases. Phase lengths are set in system-clock cycles.
//
// Ports
//   iSystemClock, iModuleResetN       clock, async active-low reset
//   iTargetWay[NumberOfWays]          way select (multi-hot = broadcast)
//   iCmdValid/iCmdType/iCmdData/iCmdLast, oCmdReady   request handshake
//   oBusy                             sequencing or session open
//   oPO_*                             per-cycle vectors to the ODDR stage
//   oDQOutEnable, oDQSOutEnable       pad driver enables
//
// state  | meaning
// IDLE   | ready for a byte; a session (CE low) may still be open
// SETUP  | CE/CLE/ALE/DQ driven, WE high (tCLS/tALS/tDS)
// WLOW   | WE low (tWP)
// WHIGH  | WE high, data held (tWH/tDH)
// HOLD   | last byte done, outputs held before CE release (tCH)
// CLOSE  | one CE-high gap before switching to a different way
module nfc_po_latch_sequencer #(
  parameter int NumberOfWays = 4,
  parameter int SetupCycles  = 1,
  parameter int WPCycles     = 2,
  parameter int WHCycles     = 2,
  parameter int HoldCycles   = 1
) (
  input  logic                      iSystemClock,
  input  logic                      iModuleResetN,
  input  logic [NumberOfWays-1:0]   iTargetWay,
  input  logic                      iCmdValid,
  input  logic [1:0]                iCmdType,
  input  logic [7:0]                iCmdData,
  input  logic                      iCmdLast,
  output logic                      oCmdReady,
  output logic                      oBusy,
  output logic [2*NumberOfWays-1:0] oPO_ChipEnable,
  output logic [3:0]                oPO_WriteEnable,
  output logic [3:0]                oPO_ReadEnable,
  output logic [3:0]                oPO_AddressLatchEnable,
  output logic [3:0]                oPO_CommandLatchEnable,
  output logic [31:0]               oPO_DQ,
  output logic [7:0]                oPO_DQStrobe,
  output logic                      oDQOutEnable,
  output logic                      oDQSOutEnable
);

  localparam int Max1   = (SetupCycles > WPCycles) ? SetupCycles : WPCycles;
  localparam int Max2   = (WHCycles > HoldCycles) ? WHCycles : HoldCycles;
  localparam int MaxCyc = (Max1 > Max2) ? Max1 : Max2;
  localparam int CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  // Counter holds "cycles remaining minus one" so a phase ends at zero.
  localparam logic [CntW-1:0] CntSetup = CntW'(SetupCycles - 1);
  localparam logic [CntW-1:0] CntWp    = CntW'(WPCycles - 1);
  localparam logic [CntW-1:0] CntWh    = CntW'(WHCycles - 1);
  localparam logic [CntW-1:0] CntHold  = CntW'(HoldCycles - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WLOW, S_WHIGH, S_HOLD, S_CLOSE
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [CntW-1:0]         r_cnt, w_cnt_nxt;
  logic [1:0]              r_type, w_type_nxt;
  logic [7:0]              r_byte, w_byte_nxt;
  logic [NumberOfWays-1:0] r_way_req, w_way_req_nxt;
  logic                    r_last, w_last_nxt;
  logic                    r_pend, w_pend_nxt;
  logic                    r_sess, w_sess_nxt;
  logic [NumberOfWays-1:0] r_sess_way, w_sess_way_nxt;

  logic [NumberOfWays-1:0] r_ce_n, w_ce_n_nxt;
  logic                    r_we_n, w_we_n_nxt;
  logic                    r_cle, w_cle_nxt;
  logic                    r_ale, w_ale_nxt;
  logic [7:0]              r_dq, w_dq_nxt;
  logic                    r_dqoe, w_dqoe_nxt;
  logic                    r_ready, w_ready_nxt;
  logic                    r_busy, w_busy_nxt;

  // A bus cycle starts either straight from IDLE (live request) or after
  // the way-change gap (request latched earlier).
  logic                    w_setup_en;
  logic [1:0]              w_src_type;
  logic [7:0]              w_src_byte;
  logic [NumberOfWays-1:0] w_src_way;

  assign w_src_type = (r_state == S_CLOSE) ? r_type    : iCmdType;
  assign w_src_byte = (r_state == S_CLOSE) ? r_byte    : iCmdData;
  assign w_src_way  = (r_state == S_CLOSE) ? r_way_req : iTargetWay;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_type_nxt     = r_type;
    w_byte_nxt     = r_byte;
    w_way_req_nxt  = r_way_req;
    w_last_nxt     = r_last;
    w_pend_nxt     = r_pend;
    w_sess_nxt     = r_sess;
    w_sess_way_nxt = r_sess_way;
    w_ce_n_nxt     = r_ce_n;
    w_we_n_nxt     = r_we_n;
    w_cle_nxt      = r_cle;
    w_ale_nxt      = r_ale;
    w_dq_nxt       = r_dq;
    w_dqoe_nxt     = r_dqoe;
    w_setup_en     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (iCmdValid) begin
          w_type_nxt    = iCmdType;
          w_byte_nxt    = iCmdData;
          w_way_req_nxt = iTargetWay;
          w_last_nxt    = iCmdLast;
          if (iCmdType == 2'b11) begin
            // Reserved type: no bus cycle, but may close an open session.
            if (iCmdLast && r_sess) begin
              w_state_nxt = S_HOLD;
              w_cnt_nxt   = CntHold;
            end
          end else if (r_sess && (iTargetWay != r_sess_way)) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = CntHold;
            w_pend_nxt  = 1'b1;
          end else begin
            w_setup_en = 1'b1;
          end
        end
      end
      S_SETUP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_WLOW;
          w_cnt_nxt   = CntWp;
          w_we_n_nxt  = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_WLOW: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_WHIGH;
          w_cnt_nxt   = CntWh;
          w_we_n_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_WHIGH: begin
        if (r_cnt == '0) begin
          if (r_last) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = CntHold;
          end else begin
            // Session stays open: CE and DQ remain, latch enables drop.
            w_state_nxt = S_IDLE;
            w_cle_nxt   = 1'b0;
            w_ale_nxt   = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_ce_n_nxt  = '1;
          w_cle_nxt   = 1'b0;
          w_ale_nxt   = 1'b0;
          w_dqoe_nxt  = 1'b0;
          w_sess_nxt  = 1'b0;
          w_state_nxt = r_pend ? S_CLOSE : S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_CLOSE: begin
        w_pend_nxt = 1'b0;
        w_setup_en = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_setup_en) begin
      w_state_nxt    = S_SETUP;
      w_cnt_nxt      = CntSetup;
      w_sess_nxt     = 1'b1;
      w_sess_way_nxt = w_src_way;
      w_ce_n_nxt     = ~w_src_way;
      w_cle_nxt      = (w_src_type == 2'b00);
      w_ale_nxt      = (w_src_type == 2'b01);
      w_dq_nxt       = w_src_byte;
      w_dqoe_nxt     = 1'b1;
      w_we_n_nxt     = 1'b1;
    end

    w_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt  = (w_state_nxt != S_IDLE) || w_sess_nxt;
  end

  always_ff @(posedge iSystemClock or negedge iModuleResetN) begin
    if (!iModuleResetN) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_type     <= 2'b00;
      r_byte     <= 8'h00;
      r_way_req  <= '0;
      r_last     <= 1'b0;
      r_pend     <= 1'b0;
      r_sess     <= 1'b0;
      r_sess_way <= '0;
      r_ce_n     <= '1;
      r_we_n     <= 1'b1;
      r_cle      <= 1'b0;
      r_ale      <= 1'b0;
      r_dq       <= 8'h00;
      r_dqoe     <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_type     <= w_type_nxt;
      r_byte     <= w_byte_nxt;
      r_way_req  <= w_way_req_nxt;
      r_last     <= w_last_nxt;
      r_pend     <= w_pend_nxt;
      r_sess     <= w_sess_nxt;
      r_sess_way <= w_sess_way_nxt;
      r_ce_n     <= w_ce_n_nxt;
      r_we_n     <= w_we_n_nxt;
      r_cle      <= w_cle_nxt;
      r_ale      <= w_ale_nxt;
      r_dq       <= w_dq_nxt;
      r_dqoe     <= w_dqoe_nxt;
      r_ready    <= w_ready_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign oCmdReady              = r_ready;
  assign oBusy                  = r_busy;
  assign oPO_ChipEnable         = {r_ce_n, r_ce_n};
  assign oPO_WriteEnable        = {4{r_we_n}};
  assign oPO_ReadEnable         = 4'hF;
  assign oPO_AddressLatchEnable = {4{r_ale}};
  assign oPO_CommandLatchEnable = {4{r_cle}};
  assign oPO_DQ                 = {8'h00, r_dq, 8'h00, r_dq};
  assign oPO_DQStrobe           = 8'h00;
  assign oDQOutEnable           = r_dqoe;
  assign oDQSOutEnable          = 1'b0;

endmodule

// File: tb/tb_nfc_po_latch_sequencer.sv
// Testbench for nfc_po_latch_sequencer: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// per-request timeline model. A second instance with stretched timing
// parameters is checked with literal WE/ready expectations.
module tb_nfc_po_latch_sequencer;

  localparam int N     = 4;
  localparam int SETUP = 1;
  localparam int WP    = 2;
  localparam int WH    = 2;
  localparam int HOLD  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic [N-1:0] way   = '0;
  logic         valid = 1'b0;
  logic [1:0]   typ   = 2'b00;
  logic [7:0]   data  = 8'h00;
  logic         last  = 1'b0;

  logic           ready, busy, dqoe, dqsoe;
  logic [2*N-1:0] ce;
  logic [3:0]     we, re, ale, cle;
  logic [31:0]    dq;
  logic [7:0]     dqs;

  nfc_po_latch_sequencer u_dut (
    .iSystemClock(clk), .iModuleResetN(rst_n), .iTargetWay(way),
    .iCmdValid(valid), .iCmdType(typ), .iCmdData(data), .iCmdLast(last),
    .oCmdReady(ready), .oBusy(busy), .oPO_ChipEnable(ce),
    .oPO_WriteEnable(we), .oPO_ReadEnable(re), .oPO_AddressLatchEnable(ale),
    .oPO_CommandLatchEnable(cle), .oPO_DQ(dq), .oPO_DQStrobe(dqs),
    .oDQOutEnable(dqoe), .oDQSOutEnable(dqsoe)
  );

  logic [N-1:0]   s_way   = 4'b0001;
  logic           s_valid = 1'b0;
  logic [1:0]     s_typ   = 2'b00;
  logic [7:0]     s_data  = 8'hA5;
  logic           s_last  = 1'b0;
  logic           s_ready, s_busy, s_dqoe, s_dqsoe;
  logic [2*N-1:0] s_ce;
  logic [3:0]     s_we, s_re, s_ale, s_cle;
  logic [31:0]    s_dq;
  logic [7:0]     s_dqs;

  nfc_po_latch_sequencer #(.SetupCycles(3), .WPCycles(1), .WHCycles(4)) u_sweep (
    .iSystemClock(clk), .iModuleResetN(rst_n), .iTargetWay(s_way),
    .iCmdValid(s_valid), .iCmdType(s_typ), .iCmdData(s_data), .iCmdLast(s_last),
    .oCmdReady(s_ready), .oBusy(s_busy), .oPO_ChipEnable(s_ce),
    .oPO_WriteEnable(s_we), .oPO_ReadEnable(s_re), .oPO_AddressLatchEnable(s_ale),
    .oPO_CommandLatchEnable(s_cle), .oPO_DQ(s_dq), .oPO_DQStrobe(s_dqs),
    .oDQOutEnable(s_dqoe), .oDQSOutEnable(s_dqsoe)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, ex);
    end
  endtask

  // ---------------- timeline model ----------------
  // Each accepted request expands into a list of per-cycle output frames.
  // When the list is empty the bus shows the idle picture of the session.
  typedef struct packed {
    logic [N-1:0] ce_n;
    logic         we_n;
    logic         cle;
    logic         ale;
    logic [7:0]   dq;
    logic         dqoe;
    logic         ready;
    logic         busy;
  } frame_t;

  frame_t       q[$];
  frame_t       exp_f;
  logic         m_sess = 1'b0;
  logic [N-1:0] m_way  = '0;
  logic [7:0]   m_dq   = 8'h00;

  function automatic frame_t idle_frame();
    frame_t f;
    f.ce_n  = m_sess ? ~m_way : '1;
    f.we_n  = 1'b1;
    f.cle   = 1'b0;
    f.ale   = 1'b0;
    f.dq    = m_dq;
    f.dqoe  = m_sess;
    f.ready = 1'b1;
    f.busy  = m_sess;
    return f;
  endfunction

  task automatic push_n(input frame_t f, input int n);
    for (int i = 0; i < n; i++) q.push_back(f);
  endtask

  task automatic model_accept(input logic [1:0] t, input logic [7:0] d,
                              input logic [N-1:0] w, input logic l);
    frame_t f;
    if (t == 2'b11) begin
      if (l && m_sess) begin
        f = idle_frame(); f.ready = 1'b0; f.busy = 1'b1;
        push_n(f, HOLD);
        m_sess = 1'b0;
      end
    end else begin
      if (m_sess && (w != m_way)) begin
        f = idle_frame(); f.ready = 1'b0; f.busy = 1'b1;
        push_n(f, HOLD);
        f.ce_n = '1; f.dqoe = 1'b0;
        push_n(f, 1);
      end
      f.ce_n = ~w; f.we_n = 1'b1; f.cle = (t == 2'b00); f.ale = (t == 2'b01);
      f.dq = d; f.dqoe = 1'b1; f.ready = 1'b0; f.busy = 1'b1;
      push_n(f, SETUP);
      f.we_n = 1'b0; push_n(f, WP);
      f.we_n = 1'b1; push_n(f, WH);
      if (l) begin
        push_n(f, HOLD);
        m_sess = 1'b0;
      end else begin
        m_sess = 1'b1;
        m_way  = w;
      end
      m_dq = d;
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_sess = 1'b0; m_way = '0; m_dq = 8'h00;
      exp_f = idle_frame();
    end else begin
      if (exp_f.ready && valid) model_accept(typ, data, way, last);
      if (q.size() > 0) exp_f = q.pop_front();
      else              exp_f = idle_frame();
    end
    #1;
    chk("m_ce",    64'(ce),    64'({exp_f.ce_n, exp_f.ce_n}));
    chk("m_we",    64'(we),    64'({4{exp_f.we_n}}));
    chk("m_re",    64'(re),    64'(4'hF));
    chk("m_cle",   64'(cle),   64'({4{exp_f.cle}}));
    chk("m_ale",   64'(ale),   64'({4{exp_f.ale}}));
    chk("m_dq",    64'(dq),    64'({8'h00, exp_f.dq, 8'h00, exp_f.dq}));
    chk("m_dqs",   64'({dqsoe, dqs}), 64'(0));
    chk("m_dqoe",  64'(dqoe),  64'(exp_f.dqoe));
    chk("m_ready", 64'(ready), 64'(exp_f.ready));
    chk("m_busy",  64'(busy),  64'(exp_f.busy));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drv(input logic v, input logic [1:0] t, input logic [7:0] d,
                     input logic [N-1:0] w, input logic l);
    valid = v; typ = t; data = d; way = w; last = l;
  endtask

  initial begin
    logic [N-1:0] ways [4];
    ways[0] = 4'b0001; ways[1] = 4'b0100; ways[2] = 4'b0011; ways[3] = 4'b0001;

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    // reset / idle
    chk("rst_ce", 64'(ce), 64'(8'hFF));
    chk("rst_we", 64'(we), 64'(4'hF));
    chk("rst_rdy_busy", 64'({ready, busy}), 64'(2'b10));
    chk("rst_dq", 64'({dq, dqoe}), 64'(0));

    // single command 0x70 on way0, last
    drv(1'b1, 2'b00, 8'h70, 4'b0001, 1'b1);
    chk("c70_t0_ready", 64'(ready), 64'(1));
    tick(); drv(1'b0, 2'b00, 8'h00, 4'b0001, 1'b0);
    chk("c70_t1_ce", 64'(ce), 64'(8'hEE));
    chk("c70_t1_cle", 64'(cle), 64'(4'hF));
    chk("c70_t1_dq", 64'(dq), 64'(32'h0070_0070));
    chk("c70_t1_dqoe", 64'(dqoe), 64'(1));
    chk("c70_t1_we", 64'(we), 64'(4'hF));
    tick(); chk("c70_t2_we", 64'(we), 64'(4'h0));
    tick(); chk("c70_t3_we", 64'(we), 64'(4'h0));
    tick(); chk("c70_t4_we", 64'(we), 64'(4'hF));
    tick(); chk("c70_t5_we", 64'(we), 64'(4'hF));
    tick(); chk("c70_t6_hold", 64'({ce, ready}), 64'({8'hEE, 1'b0}));
    tick();
    chk("c70_t7_ce", 64'(ce), 64'(8'hFF));
    chk("c70_t7_misc", 64'({cle, dqoe, ready, busy}), 64'({4'h0, 1'b0, 1'b1, 1'b0}));

    // command 0x00 then 5 address bytes, valid held throughout
    for (int k = 0; k < 6; k++) begin
      drv(1'b1, (k == 0) ? 2'b00 : 2'b01, 8'(k * 17), 4'b0001, (k == 5));
      chk("ca_ready", 64'(ready), 64'(1));
      tick();
      chk("ca_ale", 64'(ale), (k > 0) ? 64'(4'hF) : 64'(0));
      chk("ca_ce0", 64'(ce[0]), 64'(0));
      if (k == 5) drv(1'b0, 2'b00, 8'h00, 4'b0001, 1'b0);
      repeat (5) tick();
    end
    chk("ca_hold_ce", 64'(ce), 64'(8'hEE));
    tick();
    chk("ca_rel_ce", 64'(ce), 64'(8'hFF));

    // way change: session on way0, then request on way2
    drv(1'b1, 2'b00, 8'h00, 4'b0001, 1'b0);
    tick(); drv(1'b0, 2'b00, 8'h00, 4'b0001, 1'b0);
    repeat (5) tick();
    drv(1'b1, 2'b00, 8'h90, 4'b0100, 1'b1);
    tick(); drv(1'b0, 2'b00, 8'h00, 4'b0001, 1'b0);
    chk("wc_hold_ce", 64'(ce), 64'(8'hEE));
    tick(); chk("wc_gap_ce", 64'(ce), 64'(8'hFF));
    tick(); chk("wc_new_ce", 64'(ce), 64'(8'hBB));
    repeat (6) tick();
    chk("wc_rel_ce", 64'(ce), 64'(8'hFF));

    // reserved type: closes an open session, otherwise ignored
    drv(1'b1, 2'b00, 8'h00, 4'b0001, 1'b0);
    tick(); drv(1'b0, 2'b00, 8'h00, 4'b0001, 1'b0);
    repeat (5) tick();
    drv(1'b1, 2'b11, 8'hFF, 4'b0001, 1'b1);
    tick(); drv(1'b0, 2'b00, 8'h00, 4'b0001, 1'b0);
    chk("r11_hold", 64'({we, ce, ready}), 64'({4'hF, 8'hEE, 1'b0}));
    tick();
    chk("r11_rel", 64'({ce, ready, busy}), 64'({8'hFF, 1'b1, 1'b0}));
    drv(1'b1, 2'b11, 8'h55, 4'b0001, 1'b1);
    tick(); drv(1'b0, 2'b00, 8'h00, 4'b0001, 1'b0);
    chk("r11_idle", 64'({ce, ready, busy, dqoe}), 64'({8'hFF, 1'b1, 1'b0, 1'b0}));
    chk("r11_idle_dq", 64'(dq), 64'(0));

    // asynchronous reset during WE low
    drv(1'b1, 2'b10, 8'h3C, 4'b0010, 1'b1);
    tick(); drv(1'b0, 2'b00, 8'h00, 4'b0001, 1'b0);
    tick();
    chk("ar_wlow", 64'(we), 64'(4'h0));
    rst_n = 1'b0;
    #1;
    chk("ar_we", 64'(we), 64'(4'hF));
    chk("ar_ce", 64'(ce), 64'(8'hFF));
    tick(); rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      drv($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
          ways[$urandom_range(0, 3)], $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
    end
    drv(1'b0, 2'b00, 8'h00, 4'b0001, 1'b0);
    repeat (20) tick();

    // stretched timing instance: Setup=3, WP=1, WH=4
    s_valid = 1'b1; s_typ = 2'b00; s_last = 1'b0;
    chk("sw_ready0", 64'(s_ready), 64'(1));
    for (int k = 1; k <= 9; k++) begin
      tick();
      s_valid = 1'b0;
      chk("sw_we", 64'(s_we), (k == 4) ? 64'(4'h0) : 64'(4'hF));
      chk("sw_ready", 64'(s_ready), (k == 9) ? 64'(1) : 64'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
